// File: rtl/fetch_if.sv
// Fetch controller bus: instruction-memory handshake, decode output and redirect inputs.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        branch_sig;
  logic [15:0] branch_in;
  logic        jump_sig;
  logic [25:0] jump_in;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready,
           branch_sig, branch_in, jump_sig, jump_in, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready,
           branch_sig, branch_in, jump_sig, jump_in, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake,
// presents fetched words to decode and applies branch/jump redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic        w_redir;
  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jp_tgt;
  logic [31:0] w_tgt;

  // Branch wins when both redirect pulses arrive together.
  assign w_redir  = bus.branch_sig | bus.jump_sig;
  assign w_pc4    = bus.redirect_pc + 32'd4;
  assign w_br_tgt = w_pc4 + {{14{bus.branch_in[15]}}, bus.branch_in, 2'b00};
  assign w_jp_tgt = {w_pc4[31:28], bus.jump_in, 2'b00};
  assign w_tgt    = bus.branch_sig ? w_br_tgt : w_jp_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
    end else begin
      if (w_redir) begin
        r_pc    <= w_tgt;
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          r_addr  <= w_redir ? w_tgt : r_pc;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            if (w_redir) begin
              // Wrong-path data: drop it and re-request at the target.
              r_addr <= w_tgt;
            end else begin
              r_inst    <= bus.imem_rdata;
              r_inst_pc <= r_pc;
              r_valid   <= 1'b1;
              r_pc      <= r_pc + 32'd4;
              r_req     <= 1'b0;
              r_state   <= HOLD;
            end
          end else if (w_redir) begin
            // Request is outstanding; address must stay put until ack.
            r_state <= DRAIN;
          end
        end
        HOLD: begin
          if (w_redir) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            r_addr  <= w_tgt;
          end else if (bus.inst_ready) begin
            r_valid <= 1'b0;
            r_state <= FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) begin
            r_state <= FETCH;
            r_addr  <= w_redir ? w_tgt : r_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.inst_valid = r_valid;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;

endmodule
